reg_load_sequencer: RTL and testbench

Controller that sequences loading of the instruction, A and B registers from one shared 8-bit input byte stream, and selects which register owns the OR-combined output bus. It sits between the pad-level input path and the three register blocks. It fetches an instruction byte, decodes how many operand bytes follow, issues one-hot load strobes, and then sets the output select.

---
 rtl/reg_load_sequencer.sv | 168 ++++++++++++++++
 tb/tb_reg_load_sequencer.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/reg_load_sequencer.sv
// reg_load_sequencer: sequences instruction / A / B register loads from one
// shared byte stream and selects which register drives the OR-combined bus.
// Optional feature macro: SEQ_TIMEOUT_EN. When it is defined, a per-byte idle
// timeout aborts the transaction and sets err. When it is undefined, the wait
// states block indefinitely and err stays 0.
module reg_load_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       ld_ir,
  output logic       ld_a,
  output logic       ld_b,
  output logic [7:0] ld_data,
  output logic [1:0] oe_sel,
  output logic       busy,
  output logic       done,
  output logic       err
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be in 1..255");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_OPA,
    S_OPB,
    S_COMMIT
  } state_t;

  state_t     state_q, state_d;
  // {LDAB/LDB bit (byte[7]), output select (byte[5:4])}
  logic [2:0] opcode_q, opcode_d;
  logic       ld_ir_q, ld_ir_d;
  logic       ld_a_q, ld_a_d;
  logic       ld_b_q, ld_b_d;
  logic [7:0] ld_data_q, ld_data_d;
  logic [1:0] oe_sel_q, oe_sel_d;
  logic       err_q, err_d;
  logic       hs;
  logic       tmo;

  assign in_ready = (state_q == S_FETCH) || (state_q == S_OPA) || (state_q == S_OPB);
  assign hs       = in_valid && in_ready;
  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_COMMIT);
  assign ld_ir    = ld_ir_q;
  assign ld_a     = ld_a_q;
  assign ld_b     = ld_b_q;
  assign ld_data  = ld_data_q;
  assign oe_sel   = oe_sel_q;
  assign err      = err_q;

`ifdef SEQ_TIMEOUT_EN
  localparam logic [8:0] TMO_LIMIT = 9'(TIMEOUT_CYCLES);

  logic [7:0] cnt_q, cnt_d;

  // Idle-cycle counter: zero outside wait states and after each handshake.
  // The terminal count fires only when no handshake occurs, so a handshake wins.
  always_comb begin
    cnt_d = cnt_q;
    tmo   = 1'b0;
    if (!in_ready || hs) begin
      cnt_d = 8'd0;
    end else if ({1'b0, cnt_q} + 9'd1 == TMO_LIMIT) begin
      cnt_d = 8'd0;
      tmo   = 1'b1;
    end else begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  // Timeout counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= 8'd0;
    else        cnt_q <= cnt_d;
  end
`else
  assign tmo = 1'b0;
`endif

  // Next-state, load strobes, captured byte, output select and error flag
  always_comb begin
    state_d   = state_q;
    opcode_d  = opcode_q;
    ld_ir_d   = 1'b0;
    ld_a_d    = 1'b0;
    ld_b_d    = 1'b0;
    ld_data_d = ld_data_q;
    oe_sel_d  = oe_sel_q;
    err_d     = err_q;
    if (hs) ld_data_d = in_data;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_FETCH;
          err_d    = 1'b0;
          oe_sel_d = 2'b00;
        end
      end
      S_FETCH: begin
        if (hs) begin
          opcode_d = {in_data[7], in_data[5:4]};
          ld_ir_d  = 1'b1;
          case (in_data[7:6])
            2'b00:   state_d = S_COMMIT;
            2'b10:   state_d = S_OPB;
            default: state_d = S_OPA;
          endcase
        end
      end
      S_OPA: begin
        if (hs) begin
          ld_a_d  = 1'b1;
          // OPA is only reached for LDA (01) and LDAB (11); byte[7] tells them apart.
          state_d = opcode_q[2] ? S_OPB : S_COMMIT;
        end
      end
      S_OPB: begin
        if (hs) begin
          ld_b_d  = 1'b1;
          state_d = S_COMMIT;
        end
      end
      S_COMMIT: begin
        oe_sel_d = opcode_q[1:0];
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (tmo) begin
      state_d  = S_IDLE;
      err_d    = 1'b1;
      oe_sel_d = 2'b00;
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      opcode_q  <= 3'b000;
      ld_ir_q   <= 1'b0;
      ld_a_q    <= 1'b0;
      ld_b_q    <= 1'b0;
      ld_data_q <= 8'h00;
      oe_sel_q  <= 2'b00;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      opcode_q  <= opcode_d;
      ld_ir_q   <= ld_ir_d;
      ld_a_q    <= ld_a_d;
      ld_b_q    <= ld_b_d;
      ld_data_q <= ld_data_d;
      oe_sel_q  <= oe_sel_d;
      err_q     <= err_d;
    end
  end

endmodule

// File: tb/tb_reg_load_sequencer.sv
// Testbench for reg_load_sequencer: directed scenarios followed by random
// traffic, all compared against a transaction-level reference model.
module tb_reg_load_sequencer;

  localparam int TMO = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_ready, ld_ir, ld_a, ld_b, busy, done, err;
  logic [7:0] ld_data;
  logic [1:0] oe_sel;

  reg_load_sequencer #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .ld_ir(ld_ir), .ld_a(ld_a), .ld_b(ld_b), .ld_data(ld_data),
    .oe_sel(oe_sel), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: a transaction is an opcode byte followed by a list of
  // operand destinations derived from opcode bits 6 (A) and 7 (B).
  bit         m_active, m_have_op, m_commit, m_err;
  logic [7:0] m_op, m_ld_data;
  logic [1:0] m_oe;
  int         m_wait;
  int         m_ld;      // 0 none, 1 A, 2 B, 3 IR
  int         m_pend[$];

  task automatic model_reset();
    m_active = 0; m_have_op = 0; m_commit = 0; m_err = 0;
    m_op = 8'h00; m_ld_data = 8'h00; m_oe = 2'b00; m_wait = 0; m_ld = 0;
    m_pend.delete();
  endtask

  task automatic model_step();
    m_ld = 0;
    if (!rst_n) begin
      model_reset();
      return;
    end
    if (!m_active) begin
      if (start) begin
        m_active = 1; m_have_op = 0; m_err = 0; m_oe = 2'b00; m_wait = 0;
      end
    end else if (m_commit) begin
      m_oe = m_op[5:4];
      m_active = 0;
      m_commit = 0;
    end else if (in_valid) begin
      m_ld_data = in_data;
      m_wait = 0;
      if (!m_have_op) begin
        m_have_op = 1;
        m_op = in_data;
        m_ld = 3;
        m_pend.delete();
        if (in_data[6]) m_pend.push_back(1);
        if (in_data[7]) m_pend.push_back(2);
      end else begin
        m_ld = m_pend.pop_front();
      end
      if (m_pend.size() == 0) m_commit = 1;
    end
`ifdef SEQ_TIMEOUT_EN
    else begin
      m_wait++;
      if (m_wait == TMO) begin
        m_active = 0; m_err = 1; m_oe = 2'b00;
        m_pend.delete();
      end
    end
`endif
  endtask

  task automatic check_outputs();
    check_eq("in_ready", 32'(in_ready), 32'(m_active && !m_commit));
    check_eq("busy", 32'(busy), 32'(m_active));
    check_eq("done", 32'(done), 32'(m_commit));
    check_eq("ld_ir", 32'(ld_ir), 32'(m_ld == 3));
    check_eq("ld_a", 32'(ld_a), 32'(m_ld == 1));
    check_eq("ld_b", 32'(ld_b), 32'(m_ld == 2));
    check_eq("oe_sel", 32'(oe_sel), 32'(m_oe));
    check_eq("err", 32'(err), 32'(m_err));
    if (m_ld != 0) check_eq("ld_data", 32'(ld_data), 32'(m_ld_data));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic drive(input logic s, input logic v, input logic [7:0] d);
    start = s; in_valid = v; in_data = d;
    cycle();
  endtask

  task automatic check_reset_values();
    check_eq("rst_in_ready", 32'(in_ready), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_ld", 32'({ld_ir, ld_a, ld_b}), 32'd0);
    check_eq("rst_ld_data", 32'(ld_data), 32'h00);
    check_eq("rst_oe_sel", 32'(oe_sel), 32'd0);
    check_eq("rst_err", 32'(err), 32'd0);
  endtask

  initial begin
    model_reset();
    // Reset then idle
    #1;
    check_reset_values();
    drive(0, 0, 8'h00);
    drive(0, 0, 8'h00);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) drive(0, 0, 8'h00);

    // LDAB streaming: IR, A and B on consecutive cycles, oe_sel = 01 afterwards
    drive(1, 0, 8'h00);
    drive(0, 1, 8'hD0);
    drive(0, 1, 8'h3C);
    drive(0, 1, 8'h5A);
    drive(0, 0, 8'h00);
    check_eq("ldab_oe_sel", 32'(oe_sel), 32'd1);
    drive(0, 0, 8'h00);

    // LDB with a 3-cycle stall before the operand
    drive(1, 0, 8'h00);
    drive(0, 1, 8'hA0);
    for (int i = 0; i < 3; i++) drive(0, 0, 8'hFF);
    drive(0, 1, 8'h77);
    drive(0, 0, 8'h00);
    check_eq("ldb_oe_sel", 32'(oe_sel), 32'd2);

    // Withheld operand after LDA
    drive(1, 0, 8'h00);
    drive(0, 1, 8'h40);
    for (int i = 0; i < 6; i++) drive(0, 0, 8'h00);
`ifdef SEQ_TIMEOUT_EN
    check_eq("tmo_err", 32'(err), 32'd1);
    check_eq("tmo_busy", 32'(busy), 32'd0);
    drive(1, 0, 8'h00);
    check_eq("tmo_err_clear", 32'(err), 32'd0);
    drive(0, 1, 8'h00);
    drive(0, 0, 8'h00);
`else
    check_eq("block_busy", 32'(busy), 32'd1);
    check_eq("block_err", 32'(err), 32'd0);
    drive(0, 1, 8'h12);
    drive(0, 0, 8'h00);
`endif
    drive(0, 0, 8'h00);

    // start pulsed while in OPA is ignored
    drive(1, 0, 8'h00);
    drive(0, 1, 8'hE0);
    drive(1, 0, 8'h00);
    drive(0, 1, 8'h21);
    drive(1, 1, 8'h43);
    drive(0, 0, 8'h00);
    check_eq("busy_start_oe", 32'(oe_sel), 32'd2);
    drive(0, 0, 8'h00);

    // Asynchronous reset while in OPB
    drive(1, 0, 8'h00);
    drive(0, 1, 8'hF0);
    drive(0, 1, 8'h11);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check_reset_values();
    model_reset();
    drive(0, 0, 8'h00);
    rst_n = 1'b1;
    drive(0, 0, 8'h00);
    drive(0, 0, 8'h00);

    // NOP with select 11: ld_ir and done together, oe_sel = 11 next cycle
    drive(1, 0, 8'h00);
    drive(0, 1, 8'h30);
    check_eq("nop_ld_ir", 32'(ld_ir), 32'd1);
    check_eq("nop_done", 32'(done), 32'd1);
    drive(0, 0, 8'h00);
    check_eq("nop_oe_sel", 32'(oe_sel), 32'd3);

    // Random traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      rst_n = ($urandom_range(0, 299) != 0);
      drive(logic'($urandom_range(0, 3) == 0), logic'($urandom_range(0, 9) < 6),
            8'($urandom));
    end
    rst_n = 1'b1;
    drive(0, 0, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
